mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: minimum cycles a memory strobe SHALL be held (legal range 1..15).
REQ-002 Parameter TIMEOUT, default 15: cycle count in an access state at which the access SHALL abort (TIMEOUT > WAIT_CYCLES, at most 255).
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 clear  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  access request, sampled in IDLE only.
REQ-006 write  in  1  access type, 0 read / 1 write, sampled with req.
REQ-007 mem_ack  in  1  memory chip ready.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  one-cycle timeout pulse, coincident with done.
REQ-011 mar_in  out  1  MAR load enable.
REQ-012 mdr_in  out  1  MDR load enable.
REQ-013 mdr_read  out  1  MDR mux select, 1 selects memory chip and 0 selects bus.
REQ-014 mem_rd, mem_wr  out  1 each  memory strobes, never high together.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, MAR, RD, LATCH, WR, DONE.
REQ-016 IDLE with req=1: the FSM SHALL latch write into op and go to MAR; req=0 SHALL stay in IDLE.
REQ-017 MAR: mar_in=1 for one cycle; if op=write, mdr_in=1 and mdr_read=0 in the same cycle (MDR loads from bus); next state SHALL be RD (read) or WR (write).
REQ-018 RD: mem_rd=1 and mdr_read=1; WR: mem_wr=1 and mdr_read=0.
REQ-019 Wait counter SHALL be 8-bit, load 1 on entry to RD/WR, increment each further cycle there, and saturate at 255.
REQ-020 Exit from RD/WR SHALL occur at the edge where mem_ack=1 and cnt>=WAIT_CYCLES: RD goes to LATCH, WR goes to DONE.
REQ-021 With mem_ack=0 and cnt==TIMEOUT, the FSM SHALL go to DONE with err flagged; no mdr_in SHALL be asserted for that access.
REQ-022 When exit and timeout conditions coincide, exit (ack) SHALL win.
REQ-023 LATCH: mdr_in=1 and mdr_read=1 for one cycle, then DONE.
REQ-024 DONE: done=1, and err=1 if flagged, for one cycle, then IDLE; err flag SHALL clear on leaving DONE.
REQ-025 req asserted in any non-IDLE state SHALL be ignored and not queued.
REQ-026 Every output not listed as high for a state SHALL be 0 in that state; all outputs SHALL be decoded from registered state/op/flag only (Moore).
REQ-027 Latency at WAIT_CYCLES=1 with mem_ack held high: read done 4 cycles after the req edge, write done 3 cycles after.

Reset
REQ-028 clear=0 SHALL immediately force state IDLE, cnt=0, op=0, err flag=0, and all outputs 0, including mid-access (strobes drop asynchronously).
REQ-029 After clear rises, the first req SHALL be honoured at the next rising edge.

Structure
REQ-030 State encodings and default WAIT_CYCLES/TIMEOUT constants SHALL live in shared package mem_ctrl_pkg.
REQ-031 The wait counter (load/increment/saturate, compare outputs) SHALL be sub-module mem_wait_counter; everything else lives in mem_access_ctrl.

Verification
REQ-032 Read, WAIT_CYCLES=1, mem_ack=1: req=1/write=0 at edge 0 -> mar_in cycle 1, mem_rd+mdr_read cycle 2, mdr_in+mdr_read cycle 3, done cycle 4, busy cycles 1-4.
REQ-033 Write, WAIT_CYCLES=1, mem_ack=1: req=1/write=1 -> mar_in+mdr_in with mdr_read=0 cycle 1, mem_wr cycle 2, done cycle 3, mdr_read never 1.
REQ-034 Read, WAIT_CYCLES=3, mem_ack rising in 5th RD cycle -> mem_rd high exactly 5 cycles, then LATCH, then done.
REQ-035 mem_ack=0 forever, TIMEOUT=15 -> mem_rd high 15 cycles, then done=err=1 for one cycle, mdr_in never asserted.
REQ-036 clear pulsed low during RD -> mem_rd drops within the same cycle, busy=0, and a new write req after release completes normally.
REQ-037 req held high continuously -> back-to-back accesses, with exactly one IDLE cycle between done and the next mar_in.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// wait-counter width and default timing constants.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAR   = 3'd1,
        S_RD    = 3'd2,
        S_LATCH = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int unsigned CNT_W           = 8;
    localparam int unsigned DEF_WAIT_CYCLES = 1;
    localparam int unsigned DEF_TIMEOUT     = 15;

endpackage

// File: rtl/mem_wait_counter.sv
// Strobe wait counter: loads 1 on entry to a strobe state, counts up while
// the strobe is held, saturates at all-ones and is cleared otherwise.
module mem_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic inc,
    output logic wait_met,
    output logic timed_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, then saturating increment, otherwise idle at zero.
    always_comb begin
        cnt_d = '0;
        if (load) begin
            cnt_d = CNT_W'(1);
        end else if (inc) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_met  = (cnt_q >= CNT_W'(WAIT_CYCLES));
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller. Handshake: req/write are sampled only in IDLE;
// a request seen in any other state is dropped, and completion is signalled
// by a single-cycle done (with err on timeout). All outputs are decoded from
// registered state, op and error flag only.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic   clock,
    input  logic   clear,
    input  logic   req,
    input  logic   write,
    input  logic   mem_ack,
    output logic   busy,
    output logic   done,
    output logic   err,
    output logic   mar_in,
    output logic   mdr_in,
    output logic   mdr_read,
    output logic   mem_rd,
    output logic   mem_wr,
    output state_t dbg_state
);

    state_t state_q, state_d;
    logic   op_q, op_d;
    logic   err_q, err_d;
    logic   wait_met;
    logic   timed_out;
    logic   cnt_load;
    logic   cnt_inc;

    // MAR is always followed by a strobe state, so it is the load point.
    assign cnt_load = (state_q == S_MAR);
    assign cnt_inc  = (state_q == S_RD) || (state_q == S_WR);

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) u_wait_counter (
        .clock     (clock),
        .clear     (clear),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .wait_met  (wait_met),
        .timed_out (timed_out)
    );

    // Next-state logic; an acknowledged exit takes priority over timeout.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = write;
                    state_d = S_MAR;
                end
            end
            S_MAR: begin
                state_d = op_q ? S_WR : S_RD;
            end
            S_RD: begin
                if (mem_ack && wait_met) begin
                    state_d = S_LATCH;
                end else if (!mem_ack && timed_out) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_WR: begin
                if (mem_ack && wait_met) begin
                    state_d = S_DONE;
                end else if (!mem_ack && timed_out) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_LATCH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, operation and error-flag registers, cleared asynchronously.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Moore output decode; a write loads the MDR from the bus during MAR.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_q;
    assign mar_in    = (state_q == S_MAR);
    assign mdr_in    = ((state_q == S_MAR) && op_q) || (state_q == S_LATCH);
    assign mdr_read  = (state_q == S_RD) || (state_q == S_LATCH);
    assign mem_rd    = (state_q == S_RD);
    assign mem_wr    = (state_q == S_WR);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Output vector bit order:
// {busy, done, err, mar_in, mdr_in, mdr_read, mem_rd, mem_wr}.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int W = 8;

    logic clock;
    logic clear;
    logic req1;
    logic req3;
    logic write;
    logic mem_ack;

    logic busy1, done1, err1, mar_in1, mdr_in1, mdr_read1, mem_rd1, mem_wr1;
    logic busy3, done3, err3, mar_in3, mdr_in3, mdr_read3, mem_rd3, mem_wr3;
    state_t st1, st3;

    logic [W-1:0] outs1;
    logic [W-1:0] outs3;
    assign outs1 = {busy1, done1, err1, mar_in1, mdr_in1, mdr_read1, mem_rd1, mem_wr1};
    assign outs3 = {busy3, done3, err3, mar_in3, mdr_in3, mdr_read3, mem_rd3, mem_wr3};

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Default timing instance.
    mem_access_ctrl dut (
        .clock     (clock),
        .clear     (clear),
        .req       (req1),
        .write     (write),
        .mem_ack   (mem_ack),
        .busy      (busy1),
        .done      (done1),
        .err       (err1),
        .mar_in    (mar_in1),
        .mdr_in    (mdr_in1),
        .mdr_read  (mdr_read1),
        .mem_rd    (mem_rd1),
        .mem_wr    (mem_wr1),
        .dbg_state (st1)
    );

    // Longer minimum strobe instance.
    mem_access_ctrl #(.WAIT_CYCLES(3), .TIMEOUT(15)) dut3 (
        .clock     (clock),
        .clear     (clear),
        .req       (req3),
        .write     (write),
        .mem_ack   (mem_ack),
        .busy      (busy3),
        .done      (done3),
        .err       (err3),
        .mar_in    (mar_in3),
        .mdr_in    (mdr_in3),
        .mdr_read  (mdr_read3),
        .mem_rd    (mem_rd3),
        .mem_wr    (mem_wr3),
        .dbg_state (st3)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop and compare one expected vector per cycle, starting with the current cycle.
    task automatic run_expect(input bit sel, input string tag);
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            check($sformatf("%s[%0d]", tag, idx), sel ? outs3 : outs1, exp_q.pop_front());
            idx++;
            if (exp_q.size() > 0) @(negedge clock);
        end
    endtask

    task automatic issue1(input logic w);
        req1  = 1'b1;
        write = w;
        @(negedge clock);
        req1  = 1'b0;
    endtask

    task automatic issue3(input logic w);
        req3  = 1'b1;
        write = w;
        @(negedge clock);
        req3  = 1'b0;
    endtask

    initial begin
        clear   = 1'b0;
        req1    = 1'b0;
        req3    = 1'b0;
        write   = 1'b0;
        mem_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_outs1", outs1, 8'h00);
        check("rst_outs3", outs3, 8'h00);
        check("rst_state", 8'(st1), 8'(S_IDLE));
        req1 = 1'b1;
        @(negedge clock);
        check("rst_req_held", outs1, 8'h00);
        req1 = 1'b0;

        // Release and request in the same cycle: read with ack high
        clear   = 1'b1;
        mem_ack = 1'b1;
        issue1(1'b0);
        exp_q.push_back(8'h90); exp_q.push_back(8'h86); exp_q.push_back(8'h8C);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
        run_expect(1'b0, "rd_w1");

        // Write with ack high
        issue1(1'b1);
        exp_q.push_back(8'h98); exp_q.push_back(8'h81);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
        run_expect(1'b0, "wr_w1");

        // Request during an access is ignored and not queued
        mem_ack = 1'b0;
        issue1(1'b0);
        check("ign_mar", outs1, 8'h90);
        @(negedge clock);
        check("ign_rd0", outs1, 8'h86);
        req1  = 1'b1;
        write = 1'b1;
        @(negedge clock);
        check("ign_rd1", outs1, 8'h86);
        req1    = 1'b0;
        mem_ack = 1'b1;
        @(negedge clock);
        check("ign_latch", outs1, 8'h8C);
        @(negedge clock);
        check("ign_done", outs1, 8'hC0);
        @(negedge clock);
        check("ign_idle0", outs1, 8'h00);
        @(negedge clock);
        check("ign_idle1", outs1, 8'h00);

        // Timeout: no ack, 15 strobe cycles then done+err
        mem_ack = 1'b0;
        issue1(1'b0);
        exp_q.push_back(8'h90);
        for (int i = 0; i < 15; i++) exp_q.push_back(8'h86);
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'h00);
        run_expect(1'b0, "tmo");

        // Ack arriving in the timeout cycle wins
        mem_ack = 1'b0;
        issue1(1'b0);
        check("co_mar", outs1, 8'h90);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            check($sformatf("co_rd%0d", i), outs1, 8'h86);
            if (i == 15) mem_ack = 1'b1;
        end
        @(negedge clock);
        check("co_latch", outs1, 8'h8C);
        @(negedge clock);
        check("co_done", outs1, 8'hC0);
        @(negedge clock);
        check("co_idle", outs1, 8'h00);

        // WAIT_CYCLES=3 with ack already high: strobe held 3 cycles
        mem_ack = 1'b1;
        issue3(1'b0);
        exp_q.push_back(8'h90); exp_q.push_back(8'h86); exp_q.push_back(8'h86);
        exp_q.push_back(8'h86); exp_q.push_back(8'h8C); exp_q.push_back(8'hC0);
        exp_q.push_back(8'h00);
        run_expect(1'b1, "w3_early");

        // WAIT_CYCLES=3 with ack rising in the 5th strobe cycle
        mem_ack = 1'b0;
        issue3(1'b0);
        check("w3_mar", outs3, 8'h90);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            check($sformatf("w3_rd%0d", i), outs3, 8'h86);
            if (i == 5) mem_ack = 1'b1;
        end
        @(negedge clock);
        check("w3_latch", outs3, 8'h8C);
        @(negedge clock);
        check("w3_done", outs3, 8'hC0);
        @(negedge clock);
        check("w3_idle", outs3, 8'h00);

        // Asynchronous clear during RD, then a normal write
        mem_ack = 1'b0;
        issue1(1'b0);
        check("arst_mar", outs1, 8'h90);
        @(negedge clock);
        check("arst_rd", outs1, 8'h86);
        #2 clear = 1'b0;
        #1;
        check("arst_outs", outs1, 8'h00);
        check("arst_state", 8'(st1), 8'(S_IDLE));
        @(negedge clock);
        clear   = 1'b1;
        mem_ack = 1'b1;
        issue1(1'b1);
        exp_q.push_back(8'h98); exp_q.push_back(8'h81);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
        run_expect(1'b0, "arst_wr");

        // req held high: back-to-back reads with one IDLE cycle between
        mem_ack = 1'b1;
        write   = 1'b0;
        req1    = 1'b1;
        @(negedge clock);
        exp_q.push_back(8'h90); exp_q.push_back(8'h86); exp_q.push_back(8'h8C);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h00); exp_q.push_back(8'h90);
        run_expect(1'b0, "b2b");
        req1 = 1'b0;
        @(negedge clock);
        exp_q.push_back(8'h86); exp_q.push_back(8'h8C);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
        run_expect(1'b0, "b2b_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
